// File: rtl/apb_uart_regs.sv
// APB register block between the system bus and uart_core: frame config, TX word,
// start pulse, and W1C event status. Optional IER/irq_o under `APB_UART_IRQ_EN`.
module apb_uart_regs #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [1:0]        data_bit_num_o,
  output logic              parity_en_o,
  output logic              parity_type_o,
  output logic              stop_bit_num_o,
  output logic [31:0]       tx_data_o,
  output logic              start_tx_o,
  input  logic              tx_done_i,
  input  logic              rx_done_i,
  input  logic              parity_error_i,
  input  logic [31:0]       rx_data_i
`ifdef APB_UART_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam logic [2:0] OFS_TX   = 3'd0;
  localparam logic [2:0] OFS_RX   = 3'd1;
  localparam logic [2:0] OFS_CFG  = 3'd2;
  localparam logic [2:0] OFS_CTRL = 3'd3;
  localparam logic [2:0] OFS_STAT = 3'd4;
  localparam logic [2:0] OFS_IER  = 3'd5;

  logic [2:0]  ofs;
  logic        access, mapped, busy_err, err, we, start_cmd;
  logic        tx_busy;
  logic [3:0]  sts;        // {rx_overrun, parity_err, rx_done, tx_done}
  logic [3:0]  sts_set, w1c;
  logic [31:0] rx_data;
  logic [3:0]  ier;
  logic        unused_addr;

  assign unused_addr = ^{paddr[ADDR_W-1:5], paddr[1:0]};
  assign ofs    = paddr[4:2];
  assign access = psel & penable;
  assign pready = 1'b1;

  always_comb begin
    mapped = 1'b0;
    case (ofs)
      OFS_TX, OFS_RX, OFS_CFG, OFS_CTRL, OFS_STAT: mapped = 1'b1;
`ifdef APB_UART_IRQ_EN
      OFS_IER: mapped = 1'b1;
`endif
      default: mapped = 1'b0;
    endcase
  end

  // Anything that would disturb the frame in flight is refused.
  assign busy_err = pwrite & tx_busy &
                    ((ofs == OFS_TX) | (ofs == OFS_CFG) | ((ofs == OFS_CTRL) & pwdata[0]));
  assign err       = ~mapped | (pwrite & (ofs == OFS_RX)) | busy_err;
  assign pslverr   = access & err;
  assign we        = access & pwrite & ~err;
  assign start_cmd = we & (ofs == OFS_CTRL) & pwdata[0];
  assign w1c       = (we && ofs == OFS_STAT) ? pwdata[4:1] : 4'b0;
  assign sts_set   = {rx_done_i & sts[1], rx_done_i & parity_error_i, rx_done_i, tx_done_i};

`ifndef APB_UART_IRQ_EN
  assign ier = 4'b0;
`endif

  always_comb begin
    prdata = 32'b0;
    if (access && !pwrite && mapped) begin
      case (ofs)
        OFS_TX:   prdata = tx_data_o;
        OFS_RX:   prdata = rx_data;
        OFS_CFG:  prdata = {27'b0, parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o};
        OFS_STAT: prdata = {27'b0, sts, tx_busy};
        OFS_IER:  prdata = {28'b0, ier};
        default:  prdata = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_o      <= 32'b0;
      data_bit_num_o <= 2'b11;
      stop_bit_num_o <= 1'b0;
      parity_en_o    <= 1'b0;
      parity_type_o  <= 1'b0;
      start_tx_o     <= 1'b0;
      tx_busy        <= 1'b0;
      sts            <= 4'b0;
      rx_data        <= 32'b0;
    end else begin
      start_tx_o <= start_cmd;
      if (we && ofs == OFS_TX) tx_data_o <= pwdata;
      if (we && ofs == OFS_CFG)
        {parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o} <= pwdata[4:0];
      if (start_cmd)      tx_busy <= 1'b1;
      else if (tx_done_i) tx_busy <= 1'b0;
      // Hardware set beats a same-cycle software clear.
      sts <= sts_set | (sts & ~w1c);
      if (rx_done_i) rx_data <= rx_data_i;
    end
  end

`ifdef APB_UART_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier   <= 4'b0;
      irq_o <= 1'b0;
    end else begin
      if (we && ofs == OFS_IER) ier <= pwdata[3:0];
      irq_o <= |(sts & ier);
    end
  end
`endif

endmodule

// File: tb/tb_apb_uart_regs.sv
// Self-checking bench for apb_uart_regs: directed scenarios plus a randomized run
// against a behavioural register-map model.
module tb_apb_uart_regs;
  logic        clk = 0, rst_n = 0;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = 0;
  logic [31:0] pwdata = 0, prdata;
  logic        pready, pslverr;
  logic [1:0]  data_bit_num_o;
  logic        parity_en_o, parity_type_o, stop_bit_num_o;
  logic [31:0] tx_data_o;
  logic        start_tx_o;
  logic        tx_done_i = 0, rx_done_i = 0, parity_error_i = 0;
  logic [31:0] rx_data_i = 0;
`ifdef APB_UART_IRQ_EN
  logic        irq_o;
`endif

  int n_cmp = 0, n_err = 0;

  apb_uart_regs #(.ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .data_bit_num_o(data_bit_num_o), .parity_en_o(parity_en_o), .parity_type_o(parity_type_o),
    .stop_bit_num_o(stop_bit_num_o), .tx_data_o(tx_data_o), .start_tx_o(start_tx_o),
    .tx_done_i(tx_done_i), .rx_done_i(rx_done_i), .parity_error_i(parity_error_i),
    .rx_data_i(rx_data_i)
`ifdef APB_UART_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model of the register map
  logic [31:0] m_tx, m_rx;
  logic [4:0]  m_cfg;
  logic [3:0]  m_ier;
  bit          m_busy, m_txdone, m_rxdone, m_perr, m_ovr;

  function automatic logic [31:0] m_status();
    return 32'(m_busy) + 32'(m_txdone) * 2 + 32'(m_rxdone) * 4 + 32'(m_perr) * 8 + 32'(m_ovr) * 16;
  endfunction

  function automatic void m_reset();
    m_tx = 0; m_rx = 0; m_cfg = 5'd3; m_ier = 0;
    m_busy = 0; m_txdone = 0; m_rxdone = 0; m_perr = 0; m_ovr = 0;
  endfunction

  function automatic bit m_mapped(int o);
`ifdef APB_UART_IRQ_EN
    return o <= 5;
`else
    return o <= 4;
`endif
  endfunction

  // Applies a write to the model; returns expected pslverr, sets whether a start pulse follows.
  function automatic bit m_write(int o, logic [31:0] d, output bit pulse);
    pulse = 0;
    if (!m_mapped(o) || o == 1) return 1;
    if (m_busy && (o == 0 || o == 2 || (o == 3 && d[0]))) return 1;
    case (o)
      0: m_tx = d;
      2: m_cfg = d[4:0];
      3: if (d[0]) begin m_busy = 1; pulse = 1; end
      4: begin
           if (d[1]) m_txdone = 0;
           if (d[2]) m_rxdone = 0;
           if (d[3]) m_perr = 0;
           if (d[4]) m_ovr = 0;
         end
      5: m_ier = d[3:0];
      default: ;
    endcase
    return 0;
  endfunction

  function automatic logic [31:0] m_read(int o);
    case (o)
      0: return m_tx;
      1: return m_rx;
      2: return {27'b0, m_cfg};
      4: return m_status();
      5: return m_mapped(5) ? {28'b0, m_ier} : 32'b0;
      default: return 0;
    endcase
  endfunction

  function automatic void m_event(bit tx, bit rx, bit pe, logic [31:0] d);
    if (tx) begin m_busy = 0; m_txdone = 1; end
    if (rx) begin
      if (m_rxdone) m_ovr = 1;
      m_rxdone = 1; m_rx = d;
      if (pe) m_perr = 1;
    end
  endfunction

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
    @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1; #1 e = pslverr;
    @(negedge clk); psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(negedge clk); penable = 1; #1 begin d = prdata; e = pslverr; end
    @(negedge clk); psel = 0; penable = 0;
  endtask

  task automatic pulse_ev(input bit tx, input bit rx, input bit pe, input logic [31:0] d);
    @(negedge clk); tx_done_i = tx; rx_done_i = rx; parity_error_i = pe; rx_data_i = d;
    @(negedge clk); tx_done_i = 0; rx_done_i = 0; parity_error_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; repeat (2) @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    do_reset();
    n_cmp++; if (start_tx_o !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start_tx_o); end
    n_cmp++; if (tx_data_o !== 32'h0) begin n_err++; $display("FAIL reset_txdata: got %h want 0", tx_data_o); end
    n_cmp++; if ({parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o} !== 5'h03) begin n_err++; $display("FAIL reset_cfg_out: got %h want 03", {parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o}); end
    n_cmp++; if (pready !== 1'b1) begin n_err++; $display("FAIL pready: got %b want 1", pready); end
    apb_read(12'h008, d, e);
    n_cmp++; if (d !== 32'h3 || e !== 1'b0) begin n_err++; $display("FAIL reset_cfg: got %h/%b want 00000003/0", d, e); end
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_tx();
    logic [31:0] d; logic e;
    apb_write(12'h000, 32'hA5, e);
    apb_write(12'h008, 32'h19, e);
    apb_write(12'h00C, 32'h1, e);
    n_cmp++; if (start_tx_o !== 1'b1) begin n_err++; $display("FAIL start_high: got %b want 1", start_tx_o); end
    @(negedge clk);
    n_cmp++; if (start_tx_o !== 1'b0) begin n_err++; $display("FAIL start_low: got %b want 0", start_tx_o); end
    n_cmp++; if (tx_data_o !== 32'hA5 || parity_en_o !== 1 || parity_type_o !== 1 || data_bit_num_o !== 2'b01 || stop_bit_num_o !== 0)
      begin n_err++; $display("FAIL tx_outputs: got %h %b%b%b%b want a5 1 1 0 01", tx_data_o, parity_en_o, parity_type_o, stop_bit_num_o, data_bit_num_o); end
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL status_busy: got %h want 1", d); end
    pulse_ev(1, 0, 0, 0);
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL status_txdone: got %h want 2", d); end
  endtask

  task automatic test_busy();
    logic e; int pulses = 0;
    apb_write(12'h00C, 32'h1, e);
    apb_write(12'h00C, 32'h1, e);
    if (start_tx_o) pulses++;
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL busy_ctrl_err: got %b want 1", e); end
    apb_write(12'h000, 32'h55, e);
    if (start_tx_o) pulses++;
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL busy_tx_err: got %b want 1", e); end
    apb_write(12'h008, 32'h02, e);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL busy_cfg_err: got %b want 1", e); end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL busy_pulse: got %0d want 0", pulses); end
    n_cmp++; if (tx_data_o !== 32'hA5 || data_bit_num_o !== 2'b01) begin n_err++; $display("FAIL busy_stable: got %h/%b want a5/01", tx_data_o, data_bit_num_o); end
    pulse_ev(1, 0, 0, 0);
  endtask

  task automatic test_rx();
    logic [31:0] d; logic e;
    apb_write(12'h010, 32'h1E, e);
    pulse_ev(0, 1, 1, 32'h3C);
    pulse_ev(0, 1, 0, 32'h7E);
    apb_read(12'h004, d, e);
    n_cmp++; if (d !== 32'h7E) begin n_err++; $display("FAIL rx_data: got %h want 7e", d); end
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h1C) begin n_err++; $display("FAIL rx_status: got %h want 1c", d); end
    // W1C in the same cycle as a fresh rx_done
    @(negedge clk); psel = 1; pwrite = 1; paddr = 12'h010; pwdata = 32'h1C;
    @(negedge clk); penable = 1; rx_done_i = 1; rx_data_i = 32'h11;
    @(negedge clk); psel = 0; penable = 0; pwrite = 0; rx_done_i = 0;
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h14) begin n_err++; $display("FAIL set_wins: got %h want 14", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e;
    apb_read(12'h018, d, e);
    n_cmp++; if (d !== 32'h0 || e !== 1'b1) begin n_err++; $display("FAIL unmapped_rd: got %h/%b want 0/1", d, e); end
    apb_write(12'h004, 32'hDEAD, e);
    n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL rxdata_wr: got %b want 1", e); end
    apb_read(12'h004, d, e);
    n_cmp++; if (d !== 32'h11) begin n_err++; $display("FAIL rxdata_kept: got %h want 11", d); end
    apb_write(12'h01C, 32'h1E, e);
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h14) begin n_err++; $display("FAIL unmapped_nochg: got %h want 14", d); end
    apb_read(12'h00C, d, e);
    n_cmp++; if (d !== 32'h0 || e !== 1'b0) begin n_err++; $display("FAIL ctrl_rd: got %h/%b want 0/0", d, e); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] d; logic e;
    apb_write(12'h000, 32'h77, e);
    apb_write(12'h00C, 32'h1, e);
    @(negedge clk); #2 rst_n = 0;
    #1;
    n_cmp++; if (tx_data_o !== 32'h0 || data_bit_num_o !== 2'b11 || start_tx_o !== 0) begin n_err++; $display("FAIL async_reset: got %h/%b/%b want 0/11/0", tx_data_o, data_bit_num_o, start_tx_o); end
    @(negedge clk); rst_n = 1;
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL inflight_status: got %h want 0", d); end
    pulse_ev(1, 0, 0, 0);
    apb_read(12'h010, d, e);
    n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL late_txdone: got %h want 2", d); end
  endtask

`ifdef APB_UART_IRQ_EN
  task automatic test_irq();
    logic e;
    apb_write(12'h010, 32'h1E, e);
    apb_write(12'h014, 32'h2, e);
    pulse_ev(0, 1, 0, 32'h5);
    n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq_o); end
    @(negedge clk);
    n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq_o); end
    apb_write(12'h010, 32'h4, e);
    n_cmp++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b want 1", irq_o); end
    @(negedge clk);
    n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_clr: got %b want 0", irq_o); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] d, exp_d; logic e; bit exp_e, pulse;
    do_reset(); m_reset();
    for (int i = 0; i < 400; i++) begin
      int o = $urandom_range(0, 7);
      logic [11:0] a = 12'(($urandom & 32'hFE0) | (o << 2));
      case ($urandom_range(0, 2))
        0: begin
             d = $urandom;
             if ($urandom_range(0, 1)) d[0] = 1'b1;
             exp_e = m_write(o, d, pulse);
             apb_write(a, d, e);
             n_cmp++; if (e !== exp_e) begin n_err++; $display("FAIL rnd_wr_err[%0d] ofs %0d: got %b want %b", i, o, e, exp_e); end
             n_cmp++; if (start_tx_o !== pulse) begin n_err++; $display("FAIL rnd_start[%0d]: got %b want %b", i, start_tx_o, pulse); end
           end
        1: begin
             exp_d = m_read(o); exp_e = !m_mapped(o);
             apb_read(a, d, e);
             n_cmp++; if (d !== exp_d || e !== exp_e) begin n_err++; $display("FAIL rnd_rd[%0d] ofs %0d: got %h/%b want %h/%b", i, o, d, e, exp_d, exp_e); end
           end
        default: begin
             bit tx = 1'($urandom_range(0, 1)), rx = 1'($urandom_range(0, 1));
             bit pe = rx & 1'($urandom_range(0, 1));
             d = $urandom;
             m_event(tx, rx, pe, d);
             pulse_ev(tx, rx, pe, d);
           end
      endcase
      n_cmp++; if (tx_data_o !== m_tx || {parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o} !== m_cfg)
        begin n_err++; $display("FAIL rnd_outs[%0d]: got %h/%h want %h/%h", i, tx_data_o, {parity_type_o, parity_en_o, stop_bit_num_o, data_bit_num_o}, m_tx, m_cfg); end
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_busy();
    test_rx();
    test_errors();
    test_reset_inflight();
`ifdef APB_UART_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
